// File: rtl/exec_stage.sv
// Execute stage with operand forwarding, ALU, destination select, an iterative
// shift-add multiplier, and the EX/MEM pipeline register feeding the memory stage.
module exec_stage #(
    parameter int WIDTH = 32
) (
    input  logic             CLK,
    input  logic             CLR,
    input  logic             RegWriteE,
    input  logic             MemToRegE,
    input  logic             MemWriteE,
    input  logic [2:0]       ALUControlE,
    input  logic             ALUSrcE,
    input  logic             RegDstE,
    input  logic [WIDTH-1:0] RD1E,
    input  logic [WIDTH-1:0] RD2E,
    input  logic [4:0]       RtE,
    input  logic [4:0]       RdE,
    input  logic [WIDTH-1:0] SignImmE,
    input  logic [1:0]       ForwardAE,
    input  logic [1:0]       ForwardBE,
    input  logic [WIDTH-1:0] ResultW,
    output logic [4:0]       WriteRegE,
    output logic             BusyE,
    output logic             RegWriteM,
    output logic             MemToRegM,
    output logic             MemWriteM,
    output logic [WIDTH-1:0] ALUOutM,
    output logic [WIDTH-1:0] WriteDataM,
    output logic [4:0]       WriteRegM
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
    localparam logic [2:0] OP_MUL = 3'b011;

    typedef enum logic {IDLE, RUN} state_t;

    state_t           r_state;
    logic [CW-1:0]    r_count;
    logic [WIDTH-1:0] r_mulA;
    logic [WIDTH-1:0] r_mulB;
    logic [WIDTH-1:0] r_acc;
    logic             r_shRegWrite;
    logic             r_shMemToReg;
    logic             r_shMemWrite;
    logic [4:0]       r_shWriteReg;

    logic             r_regWriteM;
    logic             r_memToRegM;
    logic             r_memWriteM;
    logic [WIDTH-1:0] r_aluOutM;
    logic [WIDTH-1:0] r_writeDataM;
    logic [4:0]       r_writeRegM;

    logic [WIDTH-1:0] w_srcA;
    logic [WIDTH-1:0] w_fwdB;
    logic [WIDTH-1:0] w_srcB;
    logic [WIDTH-1:0] w_aluResult;
    logic [WIDTH-1:0] w_accNext;
    logic             w_slt;

    // Codes 00 and 11 both select the register-file operand.
    function automatic logic [WIDTH-1:0] fwd(input logic [1:0] sel, input logic [WIDTH-1:0] rd);
        case (sel)
            2'b01:   fwd = ResultW;
            2'b10:   fwd = r_aluOutM;
            default: fwd = rd;
        endcase
    endfunction

    assign w_srcA    = fwd(ForwardAE, RD1E);
    assign w_fwdB    = fwd(ForwardBE, RD2E);
    assign w_srcB    = ALUSrcE ? SignImmE : w_fwdB;
    assign WriteRegE = RegDstE ? RdE : RtE;
    assign w_slt     = $signed(w_srcA) < $signed(w_srcB);
    assign w_accNext = r_mulB[0] ? (r_acc + r_mulA) : r_acc;

    always_comb begin
        w_aluResult = '0;
        case (ALUControlE)
            3'b000:  w_aluResult = w_srcA & w_srcB;
            3'b001:  w_aluResult = w_srcA | w_srcB;
            3'b010:  w_aluResult = w_srcA + w_srcB;
            3'b110:  w_aluResult = w_srcA - w_srcB;
            3'b111:  w_aluResult = {{(WIDTH-1){1'b0}}, w_slt};
            default: w_aluResult = '0;
        endcase
    end

    // Busy covers the issue cycle and every RUN cycle but the last, so the
    // pipeline restarts in time to present the next instruction right after completion.
    assign BusyE = !CLR && (((r_state == IDLE) && (ALUControlE == OP_MUL)) ||
                            ((r_state == RUN) && (r_count != LAST)));

    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            r_state      <= IDLE;
            r_count      <= '0;
            r_mulA       <= '0;
            r_mulB       <= '0;
            r_acc        <= '0;
            r_shRegWrite <= 1'b0;
            r_shMemToReg <= 1'b0;
            r_shMemWrite <= 1'b0;
            r_shWriteReg <= '0;
            r_regWriteM  <= 1'b0;
            r_memToRegM  <= 1'b0;
            r_memWriteM  <= 1'b0;
            r_aluOutM    <= '0;
            r_writeDataM <= '0;
            r_writeRegM  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (ALUControlE == OP_MUL) begin
                        r_mulA       <= w_srcA;
                        r_mulB       <= w_srcB;
                        r_acc        <= '0;
                        r_count      <= '0;
                        r_shRegWrite <= RegWriteE;
                        r_shMemToReg <= MemToRegE;
                        r_shMemWrite <= MemWriteE;
                        r_shWriteReg <= WriteRegE;
                        r_regWriteM  <= 1'b0;
                        r_memToRegM  <= 1'b0;
                        r_memWriteM  <= 1'b0;
                        r_aluOutM    <= '0;
                        r_writeDataM <= '0;
                        r_writeRegM  <= '0;
                        r_state      <= RUN;
                    end else begin
                        r_regWriteM  <= RegWriteE;
                        r_memToRegM  <= MemToRegE;
                        r_memWriteM  <= MemWriteE;
                        r_aluOutM    <= w_aluResult;
                        r_writeDataM <= w_fwdB;
                        r_writeRegM  <= WriteRegE;
                    end
                end
                RUN: begin
                    r_acc   <= w_accNext;
                    r_mulA  <= r_mulA << 1;
                    r_mulB  <= r_mulB >> 1;
                    r_count <= r_count + 1'b1;
                    r_writeDataM <= '0;
                    if (r_count == LAST) begin
                        r_regWriteM <= r_shRegWrite;
                        r_memToRegM <= r_shMemToReg;
                        r_memWriteM <= r_shMemWrite;
                        r_aluOutM   <= w_accNext;
                        r_writeRegM <= r_shWriteReg;
                        r_state     <= IDLE;
                    end else begin
                        r_regWriteM <= 1'b0;
                        r_memToRegM <= 1'b0;
                        r_memWriteM <= 1'b0;
                        r_aluOutM   <= '0;
                        r_writeRegM <= '0;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign RegWriteM  = r_regWriteM;
    assign MemToRegM  = r_memToRegM;
    assign MemWriteM  = r_memWriteM;
    assign ALUOutM    = r_aluOutM;
    assign WriteDataM = r_writeDataM;
    assign WriteRegM  = r_writeRegM;

endmodule

// File: tb/tb_exec_stage.sv
// Self-checking bench for exec_stage: a vector table for single-cycle ALU ops,
// plus hand-written sequences for multiply timing, back-to-back issue and reset abort.
module tb_exec_stage;

    logic        CLK;
    logic        CLR;
    logic        RegWriteE, MemToRegE, MemWriteE;
    logic [2:0]  ALUControlE;
    logic        ALUSrcE, RegDstE;
    logic [31:0] RD1E, RD2E, SignImmE, ResultW;
    logic [4:0]  RtE, RdE;
    logic [1:0]  ForwardAE, ForwardBE;
    logic [4:0]  WriteRegE;
    logic        BusyE;
    logic        RegWriteM, MemToRegM, MemWriteM;
    logic [31:0] ALUOutM, WriteDataM;
    logic [4:0]  WriteRegM;

    int nChecks = 0;
    int nFails  = 0;

    exec_stage #(.WIDTH(32)) dut (
        .CLK(CLK), .CLR(CLR),
        .RegWriteE(RegWriteE), .MemToRegE(MemToRegE), .MemWriteE(MemWriteE),
        .ALUControlE(ALUControlE), .ALUSrcE(ALUSrcE), .RegDstE(RegDstE),
        .RD1E(RD1E), .RD2E(RD2E), .RtE(RtE), .RdE(RdE), .SignImmE(SignImmE),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .ResultW(ResultW),
        .WriteRegE(WriteRegE), .BusyE(BusyE),
        .RegWriteM(RegWriteM), .MemToRegM(MemToRegM), .MemWriteM(MemWriteM),
        .ALUOutM(ALUOutM), .WriteDataM(WriteDataM), .WriteRegM(WriteRegM)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic [2:0]  aluCtl;
        logic        rw, mtr, mw, src, dst;
        logic [31:0] rd1, rd2;
        logic [4:0]  rt, rd;
        logic [31:0] imm;
        logic [1:0]  fa, fb;
        logic [31:0] resW;
        logic [31:0] expOut, expWd;
        logic [4:0]  expWr;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic driveZero();
        RegWriteE = 0; MemToRegE = 0; MemWriteE = 0; ALUControlE = 3'b000;
        ALUSrcE = 0; RegDstE = 0; RD1E = 0; RD2E = 0; RtE = 0; RdE = 0;
        SignImmE = 0; ForwardAE = 0; ForwardBE = 0; ResultW = 0;
    endtask

    // Non-bubble junk that a running multiply must ignore.
    task automatic driveGarbage();
        RegWriteE = 1; MemToRegE = 1; MemWriteE = 1; ALUControlE = 3'b010;
        ALUSrcE = 0; RegDstE = 1; RD1E = 32'h1234; RD2E = 32'h5678; RtE = 5'd30; RdE = 5'd31;
        SignImmE = 32'h77; ForwardAE = 0; ForwardBE = 0; ResultW = 32'h99;
    endtask

    task automatic applyStimulus(input vec_t v);
        RegWriteE = v.rw; MemToRegE = v.mtr; MemWriteE = v.mw; ALUControlE = v.aluCtl;
        ALUSrcE = v.src; RegDstE = v.dst; RD1E = v.rd1; RD2E = v.rd2; RtE = v.rt; RdE = v.rd;
        SignImmE = v.imm; ForwardAE = v.fa; ForwardBE = v.fb; ResultW = v.resW;
    endtask

    task automatic checkOutput(input int i, input vec_t v);
        check($sformatf("vec%0d_ALUOutM", i), ALUOutM, v.expOut);
        check($sformatf("vec%0d_WriteDataM", i), WriteDataM, v.expWd);
        check($sformatf("vec%0d_WriteRegM", i), {27'd0, WriteRegM}, {27'd0, v.expWr});
        check($sformatf("vec%0d_ctrlM", i), {29'd0, RegWriteM, MemToRegM, MemWriteM},
              {29'd0, v.rw, v.mtr, v.mw});
    endtask

    task automatic runMul(input logic [31:0] a, input logic [31:0] b, input logic [4:0] wr,
                          input string tag);
        int busy;
        int edges;
        bit bubbleOk;
        logic [31:0] expProd;
        expProd = a * b;
        driveZero();
        ALUControlE = 3'b011; RD1E = a; RD2E = b; RegWriteE = 1; RegDstE = 1; RdE = wr; RtE = 5'd1;
        #1;
        busy = 0; edges = 0; bubbleOk = 1;
        while (BusyE && edges < 40) begin
            busy++;
            @(posedge CLK); #1;
            edges++;
            if (ALUOutM !== 0 || RegWriteM !== 0 || MemWriteM !== 0 || MemToRegM !== 0 ||
                WriteDataM !== 0 || WriteRegM !== 0) bubbleOk = 0;
            driveGarbage();
            #1;
        end
        check({tag, "_busyCycles"}, busy, 32);
        check({tag, "_bubbles"}, {31'd0, bubbleOk}, 32'd1);
        @(posedge CLK); #1;
        check({tag, "_product"}, ALUOutM, expProd);
        check({tag, "_RegWriteM"}, {31'd0, RegWriteM}, 32'd1);
        check({tag, "_WriteRegM"}, {27'd0, WriteRegM}, {27'd0, wr});
        check({tag, "_WriteDataM"}, WriteDataM, 32'd0);
        check({tag, "_MemWriteM"}, {31'd0, MemWriteM}, 32'd0);
    endtask

    initial begin
        bit staleOk;
        // aluCtl rw mtr mw src dst rd1 rd2 rt rd imm fa fb resW | expOut expWd expWr
        vecs[0]  = '{3'b010, 1, 0, 0, 0, 0, 32'd60, 32'd40, 5'd3, 5'd4, 32'd0, 2'b00, 2'b00, 32'd0,
                     32'd100, 32'd40, 5'd3};
        vecs[1]  = '{3'b010, 1, 0, 0, 0, 1, 32'd5, 32'd9, 5'd2, 5'd7, 32'd0, 2'b10, 2'b00, 32'd0,
                     32'd109, 32'd9, 5'd7};
        vecs[2]  = '{3'b110, 1, 0, 0, 0, 0, 32'hFFFFFFFE, 32'd3, 5'd6, 5'd0, 32'd0, 2'b00, 2'b00, 32'd0,
                     32'hFFFFFFFB, 32'd3, 5'd6};
        vecs[3]  = '{3'b111, 1, 0, 0, 0, 0, 32'hFFFFFFFE, 32'd3, 5'd6, 5'd0, 32'd0, 2'b00, 2'b00, 32'd0,
                     32'd1, 32'd3, 5'd6};
        vecs[4]  = '{3'b111, 1, 0, 0, 0, 0, 32'd3, 32'hFFFFFFFE, 5'd8, 5'd0, 32'd0, 2'b00, 2'b00, 32'd0,
                     32'd0, 32'hFFFFFFFE, 5'd8};
        vecs[5]  = '{3'b010, 0, 0, 1, 1, 0, 32'h100, 32'h55, 5'd5, 5'd9, 32'd8, 2'b00, 2'b01, 32'hABCD,
                     32'h108, 32'hABCD, 5'd5};
        vecs[6]  = '{3'b000, 1, 0, 0, 0, 1, 32'hF0F0, 32'hFF00, 5'd1, 5'd10, 32'd0, 2'b00, 2'b00, 32'd0,
                     32'hF000, 32'hFF00, 5'd10};
        vecs[7]  = '{3'b001, 1, 0, 0, 0, 1, 32'hF0F0, 32'hFF00, 5'd1, 5'd11, 32'd0, 2'b00, 2'b00, 32'd0,
                     32'hFFF0, 32'hFF00, 5'd11};
        vecs[8]  = '{3'b100, 1, 0, 0, 0, 0, 32'hFFFF, 32'h1234, 5'd12, 5'd0, 32'd0, 2'b00, 2'b00, 32'd0,
                     32'd0, 32'h1234, 5'd12};
        vecs[9]  = '{3'b010, 1, 0, 0, 0, 0, 32'h7FFFFFFF, 32'd1, 5'd13, 5'd0, 32'd0, 2'b00, 2'b00, 32'd0,
                     32'h80000000, 32'd1, 5'd13};
        vecs[10] = '{3'b110, 1, 1, 0, 0, 0, 32'd10, 32'd20, 5'd14, 5'd0, 32'd0, 2'b11, 2'b11, 32'hDEAD,
                     32'hFFFFFFF6, 32'd20, 5'd14};
        vecs[11] = '{3'b110, 1, 0, 0, 0, 0, 32'd0, 32'd77, 5'd15, 5'd0, 32'd0, 2'b00, 2'b10, 32'd0,
                     32'd10, 32'hFFFFFFF6, 5'd15};

        // Reset with a multiply presented: busy must stay low while CLR is held.
        CLR = 1'b1;
        driveZero();
        ALUControlE = 3'b011; RD1E = 32'd7; RD2E = 32'd6;
        #12;
        check("reset_BusyE", {31'd0, BusyE}, 32'd0);
        check("reset_ALUOutM", ALUOutM, 32'd0);
        check("reset_ctrlM", {29'd0, RegWriteM, MemToRegM, MemWriteM}, 32'd0);
        check("reset_WriteDataM", WriteDataM, 32'd0);
        check("reset_WriteRegM", {27'd0, WriteRegM}, 32'd0);
        CLR = 1'b0;

        for (int i = 0; i < 12; i++) begin
            applyStimulus(vecs[i]);
            #1;
            check($sformatf("vec%0d_WriteRegE", i), {27'd0, WriteRegE}, {27'd0, vecs[i].expWr});
            check($sformatf("vec%0d_BusyE", i), {31'd0, BusyE}, 32'd0);
            @(posedge CLK); #1;
            checkOutput(i, vecs[i]);
        end

        runMul(32'd7, 32'd6, 5'd20, "mul7x6");
        runMul(32'd3, 32'd3, 5'd21, "mul3x3_b2b");
        runMul(32'hFFFFFFFF, 32'd2, 5'd22, "mulNeg1x2");

        // Abort a multiply at count 10 with CLR.
        driveZero();
        ALUControlE = 3'b011; RD1E = 32'd7; RD2E = 32'd6; RegWriteE = 1; RegDstE = 1; RdE = 5'd12;
        #1;
        for (int k = 0; k < 11; k++) begin
            @(posedge CLK); #1;
            driveGarbage();
        end
        #1;
        check("abort_busyBefore", {31'd0, BusyE}, 32'd1);
        CLR = 1'b1;
        #1;
        check("abort_BusyE", {31'd0, BusyE}, 32'd0);
        check("abort_ALUOutM", ALUOutM, 32'd0);
        check("abort_ctrlM", {29'd0, RegWriteM, MemToRegM, MemWriteM}, 32'd0);
        @(negedge CLK);
        CLR = 1'b0;
        driveZero();
        ALUControlE = 3'b010; RD1E = 32'd2; RD2E = 32'd3; RegWriteE = 1; RegDstE = 1; RdE = 5'd9;
        #1;
        check("postAbort_BusyE", {31'd0, BusyE}, 32'd0);
        @(posedge CLK); #1;
        check("postAbort_ALUOutM", ALUOutM, 32'd5);
        check("postAbort_WriteRegM", {27'd0, WriteRegM}, 32'd9);
        check("postAbort_RegWriteM", {31'd0, RegWriteM}, 32'd1);
        driveZero();
        staleOk = 1;
        for (int k = 0; k < 40; k++) begin
            @(posedge CLK); #1;
            if (ALUOutM !== 0 || RegWriteM !== 0 || BusyE !== 0) staleOk = 0;
        end
        check("postAbort_noStaleProduct", {31'd0, staleOk}, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
